tdm_demux_2ch: RTL and testbench

TDM_DEMUX_2CH -- requirements
Module: tdm_demux_2ch

---
 rtl/tdm_pkg.sv | 12 +
 rtl/tdm_demux_2ch_if.sv | 31 +++
 rtl/tdm_shift_reg.sv | 23 ++
 rtl/tdm_demux_2ch.sv | 115 +++++++++++
 tb/tb_tdm_demux_2ch.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/tdm_pkg.sv
// TDM demux shared types: FSM states and default width.
// Imported by the interface, shift register and top.
package tdm_pkg;

  localparam int TDM_WIDTH = 8;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } tdm_state_e;

endpackage

// File: rtl/tdm_demux_2ch_if.sv
// TDM demux bus: serial input side (en/din/sync) and
// decoded outputs (ch0/ch1 words, valid, sel, locked, err).
interface tdm_demux_2ch_if
  import tdm_pkg::*;
#(
  parameter int WIDTH = TDM_WIDTH
);

  logic             en;
  logic             din;
  logic             sync;
  logic [WIDTH-1:0] ch0_data;
  logic [WIDTH-1:0] ch1_data;
  logic             valid;
  logic             sel;
  logic             locked;
  logic             err;

  modport master (
    output en, din, sync,
    input  ch0_data, ch1_data,
    input  valid, sel, locked, err
  );

  modport slave (
    input  en, din, sync,
    output ch0_data, ch1_data,
    output valid, sel, locked, err
  );

endinterface

// File: rtl/tdm_shift_reg.sv
// MSB-first serial-in shift register, enable + sync reset.
// Ports: clk, rst, en, d in; q = WIDTH-bit contents.
module tdm_shift_reg
  import tdm_pkg::*;
#(
  parameter int WIDTH = TDM_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= {q[WIDTH-2:0], d};
    end
  end

endmodule

// File: rtl/tdm_demux_2ch.sv
// 2:1 TDM receiver: splits bit-interleaved serial line.
// Ports: clk, rst (sync, high), bus = tdm_demux_2ch_if.
module tdm_demux_2ch
  import tdm_pkg::*;
#(
  parameter int WIDTH = TDM_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  tdm_demux_2ch_if.slave bus
);

  localparam int CW = $clog2(2 * WIDTH);
  localparam logic [CW-1:0] LAST = CW'(2 * WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  tdm_state_e       state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             sh0_en, sh1_en;
  logic             done, err_d;
  logic [WIDTH-1:0] sh0, sh1;
  logic [WIDTH-1:0] ch0_q, ch1_q;
  logic             valid_q, err_q;

  tdm_shift_reg #(.WIDTH(WIDTH)) u_sh0 (
    .clk (clk),
    .rst (rst),
    .en  (sh0_en),
    .d   (bus.din),
    .q   (sh0)
  );

  tdm_shift_reg #(.WIDTH(WIDTH)) u_sh1 (
    .clk (clk),
    .rst (rst),
    .en  (sh1_en),
    .d   (bus.din),
    .q   (sh1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= HUNT;
      cnt     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ch0_q   <= '0;
      ch1_q   <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      valid_q <= done;
      err_q   <= err_d;
      if (done) begin
        // last bit is ch1 LSB; take it straight from din
        ch0_q <= sh0;
        ch1_q <= {sh1[WIDTH-2:0], bus.din};
      end
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sh0_en  = 1'b0;
    sh1_en  = 1'b0;
    done    = 1'b0;
    err_d   = 1'b0;
    if (bus.en) begin
      unique case (state)
        HUNT: begin
          if (bus.sync) begin
            sh0_en  = 1'b1;
            cnt_d   = ONE;
            state_d = RECV;
          end
        end
        RECV: begin
          unique case (1'b1)
            bus.sync: begin
              // restart; mid-frame sync is a framing error
              err_d  = (cnt != '0);
              sh0_en = 1'b1;
              cnt_d  = ONE;
            end
            (!bus.sync && cnt == '0): begin
              err_d   = 1'b1;
              state_d = HUNT;
            end
            (!bus.sync && cnt != '0): begin
              sh0_en = ~cnt[0];
              sh1_en = cnt[0];
              if (cnt == LAST) begin
                done  = 1'b1;
                cnt_d = '0;
              end else begin
                cnt_d = cnt + ONE;
              end
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign bus.ch0_data = ch0_q;
  assign bus.ch1_data = ch1_q;
  assign bus.valid    = valid_q;
  assign bus.err      = err_q;
  assign bus.locked   = (state == RECV);
  assign bus.sel      = (state == RECV) & cnt[0];

endmodule

// File: tb/tb_tdm_demux_2ch.sv
// Self-checking bench for tdm_demux_2ch.
// Frame table, corner sequences, random vs. queue model.
module tb_tdm_demux_2ch;
  import tdm_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tdm_demux_2ch_if #(.WIDTH(W)) bif ();

  tdm_demux_2ch #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  typedef struct {
    logic [W-1:0] c0;
    logic [W-1:0] c1;
    bit           stall;
    logic [W-1:0] exp0;
    logic [W-1:0] exp1;
  } frame_t;

  frame_t tbl[5];

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int last_vcyc = 0;
  int prev_vcyc = 0;

  bit           m_al;
  bit           m_q[$];
  logic [W-1:0] m_c0, m_c1;
  bit           m_valid, m_err;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
  endtask

  task automatic model(input bit r, e, s, d);
    m_valid = 0;
    m_err = 0;
    if (r) begin
      m_al = 0;
      m_q.delete();
      m_c0 = '0;
      m_c1 = '0;
    end else if (e) begin
      if (s) begin
        if (m_al && m_q.size() != 0) m_err = 1;
        m_q.delete();
        m_q.push_back(d);
        m_al = 1;
      end else if (m_al) begin
        if (m_q.size() == 0) begin
          m_err = 1;
          m_al = 0;
        end else begin
          m_q.push_back(d);
          if (m_q.size() == 2 * W) begin
            for (int i = 0; i < W; i++) begin
              m_c0[W-1-i] = m_q[2*i];
              m_c1[W-1-i] = m_q[2*i+1];
            end
            m_valid = 1;
            m_q.delete();
          end
        end
      end
    end
  endtask

  task automatic step(input bit r, e, s, d);
    logic [19:0] act, exp;
    bit esel;
    rst = r;
    bif.en = e;
    bif.sync = s;
    bif.din = d;
    @(posedge clk);
    #1;
    cyc++;
    model(r, e, s, d);
    esel = m_al ? bit'(m_q.size() % 2) : 1'b0;
    act = {bif.valid, bif.err, bif.locked,
           bif.sel, bif.ch0_data, bif.ch1_data};
    exp = {m_valid, m_err, m_al, esel, m_c0, m_c1};
    chk("cycle", 32'(act), 32'(exp));
    if (bif.valid) begin
      n_valid++;
      prev_vcyc = last_vcyc;
      last_vcyc = cyc;
    end
    if (bif.err) n_err++;
  endtask

  task automatic send_bits(input logic [W-1:0] c0, c1,
                           input int first, last,
                           input bit stall);
    int i = first;
    int k = 0;
    bit b;
    while (i <= last) begin
      if (stall && (k % 3 == 2)) begin
        step(0, 0, 1'($urandom), 1'($urandom));
      end else begin
        b = (i % 2 == 0) ? c0[W-1-i/2] : c1[W-1-i/2];
        step(0, 1, i == 0, b);
        i++;
      end
      k++;
    end
  endtask

  int v0, e0;

  initial begin
    tbl[0] = '{8'hA5, 8'h3C, 0, 8'hA5, 8'h3C};
    tbl[1] = '{8'hFF, 8'h00, 0, 8'hFF, 8'h00};
    tbl[2] = '{8'hC3, 8'h5A, 1, 8'hC3, 8'h5A};
    tbl[3] = '{8'h00, 8'hFF, 0, 8'h00, 8'hFF};
    tbl[4] = '{8'h96, 8'h69, 1, 8'h96, 8'h69};

    rst = 1;
    bif.en = 0;
    bif.sync = 0;
    bif.din = 0;
    step(1, 1, 1, 1);
    chk("reset", 32'({bif.valid, bif.err, bif.locked,
        bif.sel, bif.ch0_data, bif.ch1_data}), 32'(0));
    step(0, 1, 0, 1);
    chk("hunt_ignore", 32'(bif.locked), 32'(0));

    for (int t = 0; t < 5; t++) begin
      v0 = n_valid;
      e0 = n_err;
      send_bits(tbl[t].c0, tbl[t].c1, 0, 2*W-1,
                tbl[t].stall);
      chk($sformatf("frame%0d", t),
          32'({bif.valid, bif.ch0_data, bif.ch1_data}),
          32'({1'b1, tbl[t].exp0, tbl[t].exp1}));
      chk($sformatf("frame%0d_cnt", t),
          32'({n_valid - v0, n_err - e0}),
          32'({32'(1), 32'(0)}));
      if (t == 1) begin
        chk("b2b_gap", 32'(last_vcyc - prev_vcyc),
            32'(2 * W));
        chk("b2b_locked", 32'(bif.locked), 32'(1));
      end
    end

    v0 = n_valid;
    e0 = n_err;
    send_bits(8'hAA, 8'h55, 0, 6, 0);
    send_bits(8'h12, 8'h34, 0, 2*W-1, 0);
    chk("resync_data",
        32'({bif.ch0_data, bif.ch1_data}), 32'(16'h1234));
    chk("resync_valid", 32'(n_valid - v0), 32'(1));
    chk("resync_err", 32'(n_err - e0), 32'(1));

    v0 = n_valid;
    step(0, 1, 0, 1);
    chk("nosync_err", 32'({bif.err, bif.locked}),
        32'(2'b10));
    for (int i = 0; i < 20; i++)
      step(0, 1'($urandom), 0, 1'($urandom));
    chk("nosync_hold", 32'({n_valid - v0}), 32'(0));
    chk("nosync_data",
        32'({bif.ch0_data, bif.ch1_data}), 32'(16'h1234));

    v0 = n_valid;
    e0 = n_err;
    send_bits(8'h77, 8'h88, 0, 9, 0);
    step(1, 1, 1, 1);
    chk("rst_mid", 32'({bif.valid, bif.err, bif.locked,
        bif.sel, bif.ch0_data, bif.ch1_data}), 32'(0));
    send_bits(8'h01, 8'h80, 0, 2*W-1, 0);
    chk("post_rst",
        32'({bif.ch0_data, bif.ch1_data}), 32'(16'h0180));
    chk("post_rst_cnt", 32'({n_valid - v0, n_err - e0}),
        32'({32'(1), 32'(0)}));

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0)
        send_bits(8'($urandom), 8'($urandom), 0,
                  2*W-1, 1'($urandom));
      else
        step($urandom_range(0, 99) == 0,
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 11) == 0,
             1'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
